// File: rtl/mmu_port_scheduler_pkg.sv
// mmu_port_scheduler_pkg: MMU command/register/access/exception encodings shared with the MMU,
// plus the scheduler state type and the flush register order.
package mmu_port_scheduler_pkg;
   typedef enum logic [1:0] {
      MMU_CMD_NONE, MMU_CMD_READ_REG, MMU_CMD_WRITE_REG, MMU_CMD_WRITE_TLB
   } MMU_CMD_T;
   typedef enum logic [2:0] {
      MMU_REG_INDEX, MMU_REG_ENTRYLO0, MMU_REG_ENTRYLO1, MMU_REG_PAGEMASK, MMU_REG_ENTRYHI
   } MMU_REG_T;
   typedef enum logic [1:0] {MEM_ACCESS_R, MEM_ACCESS_W, MEM_ACCESS_X} MEM_ACCESS_T;
   typedef enum logic [2:0] {
      MMU_EXCEPTION_NONE, MMU_EXCEPTION_TLBMISS, MMU_EXCEPTION_TLBL, MMU_EXCEPTION_TLBS,
      MMU_EXCEPTION_MOD
   } MMU_EXCEPTION_T;
   typedef enum logic [2:0] {IDLE, XLATE, CAPTURE, FL_CLR, FL_IDX, FL_WR} MMU_SCHED_STATE_T;
   function automatic MMU_REG_T clr_reg(input logic [1:0] step);
      return step == 2'd0 ? MMU_REG_ENTRYHI :
             step == 2'd1 ? MMU_REG_PAGEMASK :
             step == 2'd2 ? MMU_REG_ENTRYLO0 : MMU_REG_ENTRYLO1;
   endfunction
endpackage

// File: rtl/mmu_flush_seq.sv
// mmu_flush_seq: step/index counters and MMU command generation for the TLB flush states.
module mmu_flush_seq
   import mmu_port_scheduler_pkg::*;
#(
   parameter int ENTRY_ADDR_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   res,
   input  logic                   start,
   input  MMU_SCHED_STATE_T       state,
   output logic                   clr_last,
   output logic                   done,
   output MMU_CMD_T               mmu_cmd,
   output MMU_REG_T               mmu_reg,
   output logic [31:0]            mmu_dataIn
);
   logic [1:0]                  step_q, step_d;
   logic [ENTRY_ADDR_WIDTH-1:0] idx_q, idx_d;
   always_ff @(posedge clk or negedge res)
      if (!res) begin
         step_q <= '0;
         idx_q  <= '0;
      end else begin
         step_q <= step_d;
         idx_q  <= idx_d;
      end
   always_comb begin
      step_d     = start ? 2'd0 : state == FL_CLR ? step_q + 2'd1 : step_q;
      idx_d      = start ? '0 : state == FL_WR ? idx_q + ENTRY_ADDR_WIDTH'(1) : idx_q;
      clr_last   = state == FL_CLR && step_q == 2'd3;
      done       = state == FL_WR && &idx_q;
      mmu_cmd    = (state == FL_CLR || state == FL_IDX) ? MMU_CMD_WRITE_REG :
                   state == FL_WR ? MMU_CMD_WRITE_TLB : MMU_CMD_NONE;
      mmu_reg    = state == FL_CLR ? clr_reg(step_q) : MMU_REG_INDEX;
      mmu_dataIn = state == FL_IDX ? 32'(idx_q) : 32'd0;
   end
endmodule

// File: rtl/mmu_port_scheduler.sv
// mmu_port_scheduler: shares the MMU translation port between I and D and runs whole-TLB flushes.
// Define MMU_SCHED_RESET_FLUSH_EN to run a full flush automatically after reset.
module mmu_port_scheduler
   import mmu_port_scheduler_pkg::*;
#(
   parameter int ENTRY_ADDR_WIDTH = 3
) (
   input  logic           clk,
   input  logic           res,
   input  logic           i_req,
   input  logic [31:0]    i_vAddr,
   output logic           i_ack,
   output logic [31:0]    i_pAddr,
   output MMU_EXCEPTION_T i_exception,
   input  logic           d_req,
   input  logic [31:0]    d_vAddr,
   input  MEM_ACCESS_T    d_accessType,
   output logic           d_ack,
   output logic [31:0]    d_pAddr,
   output MMU_EXCEPTION_T d_exception,
   input  logic           flush_req,
   output logic           busy,
   output logic           addrValid,
   output logic [31:0]    vAddr,
   output MEM_ACCESS_T    mmu_accessType,
   input  logic [31:0]    pAddr,
   input  MMU_EXCEPTION_T mmu_exception,
   output MMU_CMD_T       mmu_cmd,
   output MMU_REG_T       mmu_reg,
   output logic [31:0]    mmu_dataIn
);
`ifdef MMU_SCHED_RESET_FLUSH_EN
   localparam logic FLUSH_RST = 1'b1;
`else
   localparam logic FLUSH_RST = 1'b0;
`endif
   MMU_SCHED_STATE_T state_q, state_d;
   logic             last_q, last_d, side_q, side_d, flush_pending_q, flush_pending_d;
   logic             i_ack_q, i_ack_d, d_ack_q, d_ack_d;
   logic [31:0]      vaddr_q, vaddr_d, i_pa_q, i_pa_d, d_pa_q, d_pa_d;
   MEM_ACCESS_T      acc_q, acc_d;
   MMU_EXCEPTION_T   i_exc_q, i_exc_d, d_exc_q, d_exc_d;
   logic             i_elig, d_elig, grant_d, fl_start, clr_last, fl_done;
   // A side still showing its ack is not re-served by the request it is about to drop.
   assign i_elig   = i_req && !i_ack_q;
   assign d_elig   = d_req && !d_ack_q;
   assign grant_d  = d_elig && (!i_elig || !last_q);
   assign fl_start = state_q == IDLE && flush_pending_q;
   always_ff @(posedge clk or negedge res)
      if (!res) begin
         state_q         <= IDLE;
         last_q          <= 1'b0;
         side_q          <= 1'b0;
         flush_pending_q <= FLUSH_RST;
         i_ack_q         <= 1'b0;
         d_ack_q         <= 1'b0;
         vaddr_q         <= '0;
         i_pa_q          <= '0;
         d_pa_q          <= '0;
         acc_q           <= MEM_ACCESS_R;
         i_exc_q         <= MMU_EXCEPTION_NONE;
         d_exc_q         <= MMU_EXCEPTION_NONE;
      end else begin
         state_q         <= state_d;
         last_q          <= last_d;
         side_q          <= side_d;
         flush_pending_q <= flush_pending_d;
         i_ack_q         <= i_ack_d;
         d_ack_q         <= d_ack_d;
         vaddr_q         <= vaddr_d;
         i_pa_q          <= i_pa_d;
         d_pa_q          <= d_pa_d;
         acc_q           <= acc_d;
         i_exc_q         <= i_exc_d;
         d_exc_q         <= d_exc_d;
      end
   always_comb begin
      state_d         = state_q;
      last_d          = last_q;
      side_d          = side_q;
      flush_pending_d = flush_pending_q || flush_req;
      i_ack_d         = 1'b0;
      d_ack_d         = 1'b0;
      vaddr_d         = vaddr_q;
      acc_d           = acc_q;
      i_pa_d          = i_pa_q;
      d_pa_d          = d_pa_q;
      i_exc_d         = i_exc_q;
      d_exc_d         = d_exc_q;
      case (state_q)
         IDLE:
            if (flush_pending_q) begin
               state_d         = FL_CLR;
               flush_pending_d = flush_req;
            end else if (i_elig || d_elig) begin
               state_d = XLATE;
               side_d  = grant_d;
               last_d  = grant_d;
               vaddr_d = grant_d ? d_vAddr : i_vAddr;
               acc_d   = grant_d ? d_accessType : MEM_ACCESS_R;
            end
         XLATE:   state_d = CAPTURE;
         CAPTURE: begin
            state_d = IDLE;
            if (side_q) begin
               d_ack_d = 1'b1;
               d_pa_d  = pAddr;
               d_exc_d = mmu_exception;
            end else begin
               i_ack_d = 1'b1;
               i_pa_d  = pAddr;
               i_exc_d = mmu_exception;
            end
         end
         FL_CLR:  state_d = clr_last ? FL_IDX : FL_CLR;
         FL_IDX:  state_d = FL_WR;
         FL_WR:   state_d = fl_done ? IDLE : FL_IDX;
         default: state_d = IDLE;
      endcase
   end
   mmu_flush_seq #(.ENTRY_ADDR_WIDTH(ENTRY_ADDR_WIDTH)) u_flush (
      .clk       (clk),
      .res       (res),
      .start     (fl_start),
      .state     (state_q),
      .clr_last  (clr_last),
      .done      (fl_done),
      .mmu_cmd   (mmu_cmd),
      .mmu_reg   (mmu_reg),
      .mmu_dataIn(mmu_dataIn)
   );
   assign busy           = flush_pending_q || state_q == FL_CLR || state_q == FL_IDX || state_q == FL_WR;
   assign addrValid      = state_q == XLATE;
   assign vAddr          = vaddr_q;
   assign mmu_accessType = acc_q;
   assign i_ack          = i_ack_q;
   assign d_ack          = d_ack_q;
   assign i_pAddr        = i_pa_q;
   assign d_pAddr        = d_pa_q;
   assign i_exception    = i_exc_q;
   assign d_exception    = d_exc_q;
endmodule

// File: doc/mmu_port_scheduler.md
# mmu_port_scheduler

Shares the single translation port of the MMU between the instruction-fetch requester (I) and the load/store requester (D), and sequences the MMU's register/TLB command interface to invalidate every TLB entry on a flush request. It sits between the pipeline's two memory stages and the MMU. It owns `addrValid`, `vAddr`, `mmu_accessType`, `mmu_cmd`, `mmu_reg` and `mmu_dataIn`.

## Interface
- `ENTRY_ADDR_WIDTH`, 3: TLB index width; must match the MMU's parameter. The TLB holds 2^`ENTRY_ADDR_WIDTH` entries.

Ports:
- `clk`  in  1  clock, rising edge.
- `res`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  I-side translation request; level, held until `i_ack`.
- `i_vAddr`  in  32  I-side virtual address.
- `i_ack`  out  1  one-cycle pulse: `i_pAddr`/`i_exception` valid.
- `i_pAddr`  out  32  registered physical address.
- `i_exception`  out  `MMU_EXCEPTION_T`  registered exception.
- `d_req`, `d_vAddr`, `d_ack`, `d_pAddr`, `d_exception`: same as the I side, for D.
- `d_accessType`  in  `MEM_ACCESS_T`  D-side access type.
- `flush_req`  in  1  one-cycle pulse: invalidate the whole TLB.
- `busy`  out  1  high while a flush is pending or running.
- `addrValid`, `vAddr[31:0]`, `mmu_accessType`  out  drive the MMU translation port.
- `pAddr[31:0]`, `mmu_exception`  in  MMU translation result.
- `mmu_cmd`, `mmu_reg`, `mmu_dataIn[31:0]`  out  drive the MMU command port.

## Operation
States:
- IDLE
- XLATE: `addrValid`=1 for one cycle.
- CAPTURE: latch `pAddr`/`mmu_exception`, pulse ack.
- FL_CLR: 4 cycles. Issue `MMU_CMD_WRITE_REG` with data 0 to ENTRYHI, PAGEMASK, ENTRYLO0, ENTRYLO1, in that order.
- FL_IDX: WRITE_REG INDEX = counter.
- FL_WR: `MMU_CMD_WRITE_TLB`.
- FL_WR -> FL_IDX while counter < 2^W−1. Counter increments in FL_WR; FL_WR -> IDLE after the last index.

Rules:
- IDLE priority: pending flush > requesters. A `flush_req` arriving in any state sets `flush_pending`; FL_CLR clears it.
- I vs D uses round-robin. `last` bit = side last served; reset value I, so D wins the first tie. A lone requester is always served.
- The granted side's `vAddr` is registered on entry to XLATE. Access type: I-side = `MEM_ACCESS_R`, D-side = `d_accessType`.
- Outside command states: `mmu_cmd`=`MMU_CMD_NONE`, `mmu_dataIn`=0.
- Result registers hold until the next capture for that side.
- A flush leaves EntryHi=0, i.e. ASID 0; software must rewrite EntryHi afterwards.

## Timing
- Translation latency: `req` sampled at edge N. XLATE occupies cycle N..N+1; the MMU samples at edge N+1. Capture happens at edge N+2; ack is high during N+2..N+3. The next request can be sampled at edge N+3. Throughput is one translation per 3 cycles.
- `req` must stay high until ack. If `req` drops before ack, the translation still completes and ack still pulses.
- Flush length: 4 + 2·2^W cycles after leaving IDLE (20 for W=3). `busy` rises the cycle after `flush_req` and falls on entry to IDLE.
- `flush_req` during a flush: re-latched, and one more full flush follows.
- Reset values:
  - State IDLE; counter 0; `flush_pending` 0; `busy` 0.
  - Acks 0; `addrValid` 0; `vAddr` 0; pAddr outputs 0.
  - Exceptions `MMU_EXCEPTION_NONE`; `mmu_cmd` NONE; `mmu_reg` INDEX; `mmu_dataIn` 0; `mmu_accessType` R.
- Reset asserted mid-operation aborts immediately; no ack is produced for the interrupted request.

## Configuration
- `MMU_SCHED_RESET_FLUSH_EN` defined: `flush_pending` resets to 1, so a full flush runs automatically after reset release and `busy`=1 from reset.
- Not defined: `flush_pending` resets to 0; a flush only happens on `flush_req`.

## Structure
- `mmu.vh` gets `MMU_SCHED_STATE_T` and the state constants (IDLE, XLATE, CAPTURE, FL_CLR, FL_IDX, FL_WR).
- It reuses the existing `MMU_CMD_*`, `MMU_REG_*`, `MEM_ACCESS_*` and `MMU_EXCEPTION_*` definitions.
- One sub-module, `mmu_flush_seq`: owns the FL_* counter and command/reg/data generation, with a start/done handshake.

## Test plan
Use the real MMU with W=3; populate the TLB through the MMU command port directly.
- Flush: `flush_req` -> 20 cycles of commands, 8 WRITE_TLB commands with indices 0..7. Then `d_req` with VA {19'd1,1'b0,12'd12} -> `d_exception`=TLBMISS or TLBL (invalid).
- After writing entry 0 (VPN2 1, ASID 1, FPN 4): `i_req` with VA {19'd1,1'b0,12'd12} -> `i_ack` 3 cycles later, `i_pAddr`={1'b0,19'd4,12'd12}.
- `i_req` and `d_req` asserted together and held -> D acked first, then I, then D again (alternating every 3 cycles).
- `d_req` write to a V=0 page with `d_accessType`=W -> `d_exception`=TLBS.
- `flush_req` during XLATE -> the translation is acked first, then the flush starts; `busy`=1 throughout.
- `res` low in the middle of a flush -> all outputs return to reset values. With the macro defined, the flush restarts at index 0 after release; otherwise `busy`=0.
